// File: rtl/issue_queue_integer_pkg.sv
// Shared widths and entry layout for the integer issue queue,
// common with the dispatch unit and the other issue queues.
package issue_queue_integer_pkg;

    localparam int IQ_DATA_WIDTH   = 32;
    localparam int IQ_TAG_WIDTH    = 6;
    localparam int IQ_OPCODE_WIDTH = 4;
    localparam int IQ_DEPTH        = 4;

    typedef struct packed {
        logic                     ready;
        logic [IQ_TAG_WIDTH-1:0]  tag;
        logic [IQ_DATA_WIDTH-1:0] data;
    } iq_src_t;

    typedef struct packed {
        logic                       valid;
        logic [IQ_OPCODE_WIDTH-1:0] opcode;
        logic [IQ_TAG_WIDTH-1:0]    rd_tag;
        iq_src_t                    rs1;
        iq_src_t                    rs2;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_integer_iq_entry.sv
// One issue-queue slot: storage plus CDB tag compare and wakeup,
// applied to held operands and to operands being loaded alike.
module issue_queue_integer_iq_entry
    import issue_queue_integer_pkg::*;
#(
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    load_valid,
    input  logic [OPCODE_WIDTH-1:0] load_opcode,
    input  logic [TAG_WIDTH-1:0]    load_rd_tag,
    input  logic                    load_rs1_ready,
    input  logic [TAG_WIDTH-1:0]    load_rs1_tag,
    input  logic [DATA_WIDTH-1:0]   load_rs1_data,
    input  logic                    load_rs2_ready,
    input  logic [TAG_WIDTH-1:0]    load_rs2_tag,
    input  logic [DATA_WIDTH-1:0]   load_rs2_data,
    input  logic                    cdb_valid,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [DATA_WIDTH-1:0]   cdb_data,
    output logic                    valid,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic                    rs1_ready,
    output logic [TAG_WIDTH-1:0]    rs1_tag,
    output logic [DATA_WIDTH-1:0]   rs1_data,
    output logic                    rs2_ready,
    output logic [TAG_WIDTH-1:0]    rs2_tag,
    output logic [DATA_WIDTH-1:0]   rs2_data,
    output logic                    ready
);

    logic                  in1_ready, in2_ready;
    logic [TAG_WIDTH-1:0]  in1_tag, in2_tag;
    logic [DATA_WIDTH-1:0] in1_data, in2_data;
    logic                  wake1, wake2;

    // Wakeup sees the incoming value, so a dispatch bypass and an
    // entry shifting down both capture a same-cycle broadcast.
    always_comb begin
        in1_ready = load ? load_rs1_ready : rs1_ready;
        in1_tag   = load ? load_rs1_tag   : rs1_tag;
        in1_data  = load ? load_rs1_data  : rs1_data;
        in2_ready = load ? load_rs2_ready : rs2_ready;
        in2_tag   = load ? load_rs2_tag   : rs2_tag;
        in2_data  = load ? load_rs2_data  : rs2_data;
        wake1 = cdb_valid && !in1_ready && (in1_tag == cdb_tag);
        wake2 = cdb_valid && !in2_ready && (in2_tag == cdb_tag);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            opcode    <= '0;
            rd_tag    <= '0;
            rs1_ready <= 1'b0;
            rs1_tag   <= '0;
            rs1_data  <= '0;
            rs2_ready <= 1'b0;
            rs2_tag   <= '0;
            rs2_data  <= '0;
        end else begin
            if (load) begin
                valid   <= load_valid;
                opcode  <= load_opcode;
                rd_tag  <= load_rd_tag;
                rs1_tag <= in1_tag;
                rs2_tag <= in2_tag;
            end
            rs1_ready <= in1_ready | wake1;
            rs1_data  <= wake1 ? cdb_data : in1_data;
            rs2_ready <= in2_ready | wake2;
            rs2_data  <= wake2 ? cdb_data : in2_data;
        end
    end

    assign ready = valid & rs1_ready & rs2_ready;

endmodule

// File: rtl/issue_queue_integer.sv
// Integer reservation station: compacting age-ordered queue with
// CDB wakeup and oldest-ready select toward the integer ALU.
module issue_queue_integer
    import issue_queue_integer_pkg::*;
#(
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH,
    parameter int DEPTH        = IQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_en_integer,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic                    dispatch_rs2_valid,
    input  logic                    CDB_valid,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    output logic                    issueque_full_integer,
    input  logic                    issue_ready,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    logic [CW-1:0] count;
    logic [CW-1:0] wr_slot;
    logic          full, fire, disp, found;
    logic [SW-1:0] sel;

    logic [DEPTH-1:0] e_valid, e_ready;
    logic [DEPTH-1:0] e_rs1_ready, e_rs2_ready;
    logic [DEPTH-1:0] above, ld, ld_valid;
    logic [DEPTH-1:0] ld_rs1_ready, ld_rs2_ready;

    logic [OPCODE_WIDTH-1:0] e_opcode [DEPTH];
    logic [TAG_WIDTH-1:0]    e_rd_tag [DEPTH];
    logic [TAG_WIDTH-1:0]    e_rs1_tag [DEPTH];
    logic [TAG_WIDTH-1:0]    e_rs2_tag [DEPTH];
    logic [DATA_WIDTH-1:0]   e_rs1_data [DEPTH];
    logic [DATA_WIDTH-1:0]   e_rs2_data [DEPTH];

    logic [OPCODE_WIDTH-1:0] ld_opcode [DEPTH];
    logic [TAG_WIDTH-1:0]    ld_rd_tag [DEPTH];
    logic [TAG_WIDTH-1:0]    ld_rs1_tag [DEPTH];
    logic [TAG_WIDTH-1:0]    ld_rs2_tag [DEPTH];
    logic [DATA_WIDTH-1:0]   ld_rs1_data [DEPTH];
    logic [DATA_WIDTH-1:0]   ld_rs2_data [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign fire    = found & issue_ready;
    assign disp    = dispatch_en_integer & ~full;
    assign wr_slot = fire ? count - CW'(1) : count;

    // Oldest-ready select; 'above' marks the issued slot and
    // everything younger, i.e. the slots that shift down on issue.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        above = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && e_ready[i]) begin
                found = 1'b1;
                sel   = SW'(i);
            end
            above[i] = found;
        end
    end

    assign issue_valid    = found;
    assign issue_opcode   = found ? e_opcode[sel]   : '0;
    assign issue_rd_tag   = found ? e_rd_tag[sel]   : '0;
    assign issue_rs1_data = found ? e_rs1_data[sel] : '0;
    assign issue_rs2_data = found ? e_rs2_data[sel] : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = (i < DEPTH - 1) ? i + 1 : i;
            ld[i]           = 1'b0;
            ld_valid[i]     = 1'b0;
            ld_opcode[i]    = e_opcode[j];
            ld_rd_tag[i]    = e_rd_tag[j];
            ld_rs1_ready[i] = e_rs1_ready[j];
            ld_rs1_tag[i]   = e_rs1_tag[j];
            ld_rs1_data[i]  = e_rs1_data[j];
            ld_rs2_ready[i] = e_rs2_ready[j];
            ld_rs2_tag[i]   = e_rs2_tag[j];
            ld_rs2_data[i]  = e_rs2_data[j];
            if (fire && above[i]) begin
                ld[i]       = 1'b1;
                ld_valid[i] = (i < DEPTH - 1) && e_valid[j];
            end
            // New entry lands after the shift, overriding the top copy
            if (disp && wr_slot == CW'(i)) begin
                ld[i]           = 1'b1;
                ld_valid[i]     = 1'b1;
                ld_opcode[i]    = dispatch_opcode;
                ld_rd_tag[i]    = dispatch_rd_tag;
                ld_rs1_ready[i] = dispatch_rs1_valid;
                ld_rs1_tag[i]   = dispatch_rs1_tag;
                ld_rs1_data[i]  = dispatch_rs1_data;
                ld_rs2_ready[i] = dispatch_rs2_valid;
                ld_rs2_tag[i]   = dispatch_rs2_tag;
                ld_rs2_data[i]  = dispatch_rs2_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CW'(disp) - CW'(fire);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        issue_queue_integer_iq_entry #(
            .DATA_WIDTH  (DATA_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH),
            .OPCODE_WIDTH(OPCODE_WIDTH)
        ) u_entry (
            .clk           (clk),
            .reset         (reset),
            .load          (ld[gi]),
            .load_valid    (ld_valid[gi]),
            .load_opcode   (ld_opcode[gi]),
            .load_rd_tag   (ld_rd_tag[gi]),
            .load_rs1_ready(ld_rs1_ready[gi]),
            .load_rs1_tag  (ld_rs1_tag[gi]),
            .load_rs1_data (ld_rs1_data[gi]),
            .load_rs2_ready(ld_rs2_ready[gi]),
            .load_rs2_tag  (ld_rs2_tag[gi]),
            .load_rs2_data (ld_rs2_data[gi]),
            .cdb_valid     (CDB_valid),
            .cdb_tag       (CDB_tag),
            .cdb_data      (CDB_data),
            .valid         (e_valid[gi]),
            .opcode        (e_opcode[gi]),
            .rd_tag        (e_rd_tag[gi]),
            .rs1_ready     (e_rs1_ready[gi]),
            .rs1_tag       (e_rs1_tag[gi]),
            .rs1_data      (e_rs1_data[gi]),
            .rs2_ready     (e_rs2_ready[gi]),
            .rs2_tag       (e_rs2_tag[gi]),
            .rs2_data      (e_rs2_data[gi]),
            .ready         (e_ready[gi])
        );
    end

    assign issueque_full_integer = full;

endmodule

// File: tb/tb_issue_queue_integer.sv
// Self-checking bench for issue_queue_integer: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_issue_queue_integer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        dispatch_en_integer;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
    logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
    logic        dispatch_rs1_valid, dispatch_rs2_valid;
    logic        CDB_valid;
    logic [5:0]  CDB_tag;
    logic [31:0] CDB_data;
    logic        issueque_full_integer;
    logic        issue_ready;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [5:0]  issue_rd_tag;
    logic [31:0] issue_rs1_data, issue_rs2_data;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue_integer dut (
        .clk                  (clk),
        .reset                (reset),
        .dispatch_en_integer  (dispatch_en_integer),
        .dispatch_opcode      (dispatch_opcode),
        .dispatch_rd_tag      (dispatch_rd_tag),
        .dispatch_rs1_data    (dispatch_rs1_data),
        .dispatch_rs2_data    (dispatch_rs2_data),
        .dispatch_rs1_tag     (dispatch_rs1_tag),
        .dispatch_rs2_tag     (dispatch_rs2_tag),
        .dispatch_rs1_valid   (dispatch_rs1_valid),
        .dispatch_rs2_valid   (dispatch_rs2_valid),
        .CDB_valid            (CDB_valid),
        .CDB_tag              (CDB_tag),
        .CDB_data             (CDB_data),
        .issueque_full_integer(issueque_full_integer),
        .issue_ready          (issue_ready),
        .issue_valid          (issue_valid),
        .issue_opcode         (issue_opcode),
        .issue_rd_tag         (issue_rd_tag),
        .issue_rs1_data       (issue_rs1_data),
        .issue_rs2_data       (issue_rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  rd;
        bit          r1;
        bit          r2;
        logic [5:0]  t1;
        logic [5:0]  t2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ent_t;

    ent_t mq[$];

    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    // Reference behaviour of one clock edge, from the current inputs
    task automatic model_edge();
        int   s;
        bit   was_full;
        ent_t e;
        if (reset) begin
            mq.delete();
            return;
        end
        s = model_sel();
        was_full = (mq.size() == DEPTH);
        if (s >= 0 && issue_ready) mq.delete(s);
        foreach (mq[k]) begin
            if (CDB_valid && !mq[k].r1 && mq[k].t1 == CDB_tag) begin
                mq[k].r1 = 1;
                mq[k].d1 = CDB_data;
            end
            if (CDB_valid && !mq[k].r2 && mq[k].t2 == CDB_tag) begin
                mq[k].r2 = 1;
                mq[k].d2 = CDB_data;
            end
        end
        if (dispatch_en_integer && !was_full) begin
            e.op = dispatch_opcode;
            e.rd = dispatch_rd_tag;
            e.r1 = dispatch_rs1_valid;
            e.r2 = dispatch_rs2_valid;
            e.t1 = dispatch_rs1_tag;
            e.t2 = dispatch_rs2_tag;
            e.d1 = dispatch_rs1_data;
            e.d2 = dispatch_rs2_data;
            if (CDB_valid && !e.r1 && e.t1 == CDB_tag) begin
                e.r1 = 1;
                e.d1 = CDB_data;
            end
            if (CDB_valid && !e.r2 && e.t2 == CDB_tag) begin
                e.r2 = 1;
                e.d2 = CDB_data;
            end
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [5:0] rd,
                              input logic v1, input logic [5:0] t1,
                              input logic [31:0] d1,
                              input logic v2, input logic [5:0] t2,
                              input logic [31:0] d2);
        dispatch_en_integer = 1'b1;
        dispatch_opcode     = op;
        dispatch_rd_tag     = rd;
        dispatch_rs1_valid  = v1;
        dispatch_rs1_tag    = t1;
        dispatch_rs1_data   = d1;
        dispatch_rs2_valid  = v2;
        dispatch_rs2_tag    = t2;
        dispatch_rs2_data   = d2;
    endtask

    task automatic idle();
        dispatch_en_integer = 1'b0;
        CDB_valid           = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        issue_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", issue_valid);
        end
        n_checks++;
        if (issueque_full_integer !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full: got %b expected 0",
                     issueque_full_integer);
        end
        n_checks++;
        if ({issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data}
            !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {issue_opcode, issue_rd_tag, issue_rs1_data,
                      issue_rs2_data});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ready_dispatch();
        issue_ready = 1'b1;
        drive_disp(4'h1, 6'd5, 1, 6'd0, 32'd10, 1, 6'd0, 32'd20);
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_valid: got %b expected 1", issue_valid);
        end
        n_checks++;
        if ({issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data}
            !== {4'h1, 6'd5, 32'd10, 32'd20}) begin
            n_fail++;
            $display("FAIL ready_fields: got %h/%0d/%0d/%0d expected 1/5/10/20",
                     issue_opcode, issue_rd_tag, issue_rs1_data,
                     issue_rs2_data);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drain: got %b expected 0", issue_valid);
        end
    endtask

    task automatic test_cdb_wakeup();
        issue_ready = 1'b1;
        drive_disp(4'h2, 6'd6, 0, 6'd9, 32'd0, 1, 6'd0, 32'd5);
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_wait: got %b expected 0", issue_valid);
        end
        tick();
        CDB_valid = 1'b1;
        CDB_tag   = 6'd9;
        CDB_data  = 32'hABCD;
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_rs1_data !== 32'hABCD) begin
            n_fail++;
            $display("FAIL wake_issue: got %b/%h expected 1/abcd",
                     issue_valid, issue_rs1_data);
        end
        tick();
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        drive_disp(4'h3, 6'd8, 1, 6'd0, 32'd1, 0, 6'd3, 32'd0);
        CDB_valid = 1'b1;
        CDB_tag   = 6'd3;
        CDB_data  = 32'd77;
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_rs2_data !== 32'd77) begin
            n_fail++;
            $display("FAIL bypass: got %b/%0d expected 1/77",
                     issue_valid, issue_rs2_data);
        end
        tick();
    endtask

    task automatic test_full();
        issue_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_disp(4'h4, 6'(k), 1, 6'd0, 32'(k), 1, 6'd0, 32'd0);
            tick();
            if (k == 3) begin
                n_checks++;
                if (issueque_full_integer !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: got %b expected 0",
                             issueque_full_integer);
                end
            end
        end
        n_checks++;
        if (issueque_full_integer !== 1'b1) begin
            n_fail++;
            $display("FAIL full_set: got %b expected 1",
                     issueque_full_integer);
        end
        drive_disp(4'h4, 6'd9, 1, 6'd0, 32'd0, 1, 6'd0, 32'd0);
        tick();
        n_checks++;
        if (issueque_full_integer !== 1'b1 || issue_rd_tag !== 6'd1) begin
            n_fail++;
            $display("FAIL full_drop: got %b/%0d expected 1/1",
                     issueque_full_integer, issue_rd_tag);
        end
        drive_disp(4'h4, 6'd10, 1, 6'd0, 32'd0, 1, 6'd0, 32'd0);
        issue_ready = 1'b1;
        tick();
        idle();
        n_checks++;
        if (issueque_full_integer !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clear: got %b expected 0",
                     issueque_full_integer);
        end
        for (int k = 2; k <= 4; k++) begin
            n_checks++;
            if (issue_valid !== 1'b1 || issue_rd_tag !== 6'(k)) begin
                n_fail++;
                $display("FAIL full_order: got %b/%0d expected 1/%0d",
                         issue_valid, issue_rd_tag, k);
            end
            tick();
        end
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got %b/%0d expected 0",
                     issue_valid, issue_rd_tag);
        end
    endtask

    task automatic test_out_of_order();
        issue_ready = 1'b0;
        drive_disp(4'h5, 6'd11, 0, 6'd7, 32'd0, 1, 6'd0, 32'd2);
        tick();
        drive_disp(4'h6, 6'd12, 1, 6'd0, 32'd3, 1, 6'd0, 32'd4);
        issue_ready = 1'b1;
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd12) begin
            n_fail++;
            $display("FAIL ooo_young: got %b/%0d expected 1/12",
                     issue_valid, issue_rd_tag);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_blocked: got %b expected 0", issue_valid);
        end
        CDB_valid = 1'b1;
        CDB_tag   = 6'd7;
        CDB_data  = 32'd55;
        tick();
        idle();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd11 ||
            issue_rs1_data !== 32'd55) begin
            n_fail++;
            $display("FAIL ooo_old: got %b/%0d/%0d expected 1/11/55",
                     issue_valid, issue_rd_tag, issue_rs1_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_disp(4'h7, 6'(20 + k), 1, 6'd0, 32'd1, 1, 6'd0, 32'd2);
            tick();
        end
        n_checks++;
        if (issue_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before: got %b expected 1", issue_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({issue_valid, issueque_full_integer, issue_opcode, issue_rd_tag,
             issue_rs1_data, issue_rs2_data} !== 76'd0) begin
            n_fail++;
            $display("FAIL mid_async: got %0h expected 0",
                     {issue_valid, issue_rd_tag, issue_rs1_data});
        end
        tick();
        reset = 1'b0;
        idle();
        issue_ready = 1'b1;
        tick();
        n_checks++;
        if (issue_valid !== 1'b0 || issueque_full_integer !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got %b/%b expected 0/0",
                     issue_valid, issueque_full_integer);
        end
    endtask

    task automatic test_random();
        int          s;
        logic [73:0] exp_out;
        for (int c = 0; c < 400; c++) begin
            dispatch_en_integer = ($urandom_range(0, 9) < 6);
            dispatch_opcode     = 4'($urandom);
            dispatch_rd_tag     = 6'($urandom);
            dispatch_rs1_valid  = $urandom_range(0, 1);
            dispatch_rs2_valid  = $urandom_range(0, 1);
            dispatch_rs1_tag    = 6'($urandom_range(0, 7));
            dispatch_rs2_tag    = 6'($urandom_range(0, 7));
            dispatch_rs1_data   = $urandom;
            dispatch_rs2_data   = $urandom;
            CDB_valid           = $urandom_range(0, 1);
            CDB_tag             = 6'($urandom_range(0, 7));
            CDB_data            = $urandom;
            issue_ready         = $urandom_range(0, 1);
            tick();
            s = model_sel();
            exp_out = '0;
            if (s >= 0)
                exp_out = {mq[s].op, mq[s].rd, mq[s].d1, mq[s].d2};
            n_checks++;
            if (issue_valid !== (s >= 0) ||
                issueque_full_integer !== (mq.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: got %b/%b expected %b/%b",
                         c, issue_valid, issueque_full_integer,
                         s >= 0, mq.size() == DEPTH);
            end
            n_checks++;
            if ({issue_opcode, issue_rd_tag, issue_rs1_data,
                 issue_rs2_data} !== exp_out) begin
                n_fail++;
                $display("FAIL rand_data@%0d: got %h expected %h", c,
                         {issue_opcode, issue_rd_tag, issue_rs1_data,
                          issue_rs2_data}, exp_out);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        issue_ready = 1'b0;
        dispatch_opcode = '0;
        dispatch_rd_tag = '0;
        dispatch_rs1_data = '0;
        dispatch_rs2_data = '0;
        dispatch_rs1_tag = '0;
        dispatch_rs2_tag = '0;
        dispatch_rs1_valid = 1'b0;
        dispatch_rs2_valid = 1'b0;
        CDB_tag = '0;
        CDB_data = '0;
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_bypass();
        test_full();
        test_out_of_order();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
